fifo_wr_arbiter: RTL and testbench

//   Shares the write port of one sync_fifo among NUM_REQ producers.
//   - Round-robin arbitration; multi-beat bursts are locked to one producer until its last beat.
//   - Drives fifo w_en/wr_data and back-pressures producers from the fifo full flag.
//   - Sits directly in front of sync_fifo; the read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and the sync_fifo write port.
// master: producers plus fifo status; slave: the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_w_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;

  modport master (
    output req, req_last, req_data, fifo_full,
    input  gnt, fifo_w_en, fifo_wr_data
  );

  modport slave (
    input  req, req_last, req_data, fifo_full,
    output gnt, fifo_w_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for one sync_fifo with burst locking.
// Optional per-producer beat counters when FIFO_WR_ARB_CNT_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_,
`ifdef FIFO_WR_ARB_CNT_EN
  input  logic                  cnt_clr,
  output logic [NUM_REQ*16-1:0] beat_cnt,
`endif
  fifo_wr_arbiter_if.slave      bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  typedef logic [PtrW-1:0] ptr_t;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e             state_q, state_d;
  ptr_t               rr_ptr_q, rr_ptr_d;
  ptr_t               owner_q, owner_d;
  ptr_t               win, idx, sel;
  logic               found;
  logic [NUM_REQ-1:0] gnt_c;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(NUM_REQ - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // First requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr_t'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt_c    = '0;
    sel      = (state_q == StIdle) ? win : owner_q;
    unique case (state_q)
      StIdle: begin
        if (found && !bus.fifo_full) begin
          gnt_c[win] = 1'b1;
          if (bus.req_last[win]) begin
            rr_ptr_d = ptr_inc(win);
          end else begin
            state_d = StLocked;
            owner_d = win;
          end
        end
      end
      StLocked: begin
        // Non-owners are shut out even while the owner bubbles.
        if (bus.req[owner_q] && !bus.fifo_full) begin
          gnt_c[owner_q] = 1'b1;
          if (bus.req_last[owner_q]) begin
            state_d  = StIdle;
            rr_ptr_d = ptr_inc(owner_q);
          end
        end
      end
    endcase
  end

  // Grants are combinational, so they must be masked while reset is held.
  assign bus.gnt          = rst_ ? gnt_c : '0;
  assign bus.fifo_w_en    = |bus.gnt;
  assign bus.fifo_wr_data = bus.req_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef FIFO_WR_ARB_CNT_EN
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.gnt[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized producers
// checked against a burst-level round-robin model.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

`ifdef FIFO_WR_ARB_CNT_EN
  logic            cnt_clr;
  logic [N*16-1:0] beat_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_     (rst_),
`ifdef FIFO_WR_ARB_CNT_EN
    .cnt_clr  (cnt_clr),
    .beat_cnt (beat_cnt),
`endif
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: locked producer (-1 when free) and where the next search starts.
  int m_owner = -1;
  int m_rr    = 0;

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input logic full);
    logic [N-1:0] g;
    g = '0;
    if (full) return g;
    if (m_owner >= 0) begin
      if (r[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      if (r[(m_rr + k) % N]) begin
        g[(m_rr + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_update(input logic [N-1:0] g, input logic [N-1:0] last);
    int i;
    i = oh_idx(g);
    if (i >= 0) begin
      if (last[i]) begin
        m_owner = -1;
        m_rr    = (i + 1) % N;
      end else begin
        m_owner = i;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic [W-1:0] d, input logic l, input logic v);
    bus.req[i]            = v;
    bus.req_last[i]       = l;
    bus.req_data[i*W +: W] = d;
  endtask

  // Called one unit after a rising edge with inputs already driven.
  task automatic check_cycle(input string name, output logic [N-1:0] eg);
    int wi;
    #1;
    eg = model_gnt(bus.req, bus.fifo_full);
    checks++;
    if (bus.gnt !== eg) begin
      errors++;
      $display("FAIL %s gnt: got %b expected %b (t=%0t)", name, bus.gnt, eg, $time);
    end
    checks++;
    if (bus.fifo_w_en !== (|eg)) begin
      errors++;
      $display("FAIL %s w_en: got %b expected %b (t=%0t)", name, bus.fifo_w_en, |eg, $time);
    end
    wi = oh_idx(eg);
    if (wi >= 0) begin
      checks++;
      if (bus.fifo_wr_data !== bus.req_data[wi*W +: W]) begin
        errors++;
        $display("FAIL %s data: got %h expected %h", name, bus.fifo_wr_data,
                 bus.req_data[wi*W +: W]);
      end
    end
    model_update(eg, bus.req_last);
  endtask

  task automatic test_reset();
    logic [N-1:0] seq [5];
    logic [N-1:0] eg;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_          = 1'b0;
    bus.req       = '1;
    bus.req_last  = '1;
    bus.req_data  = 32'h44332211;
    bus.fifo_full = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.gnt !== '0 || bus.fifo_w_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_gnt: got gnt=%b w_en=%b expected 0/0", bus.gnt, bus.fifo_w_en);
      end
`ifdef FIFO_WR_ARB_CNT_EN
      checks++;
      if (beat_cnt !== '0) begin
        errors++;
        $display("FAIL reset_cnt: got %h expected 0", beat_cnt);
      end
`endif
      tick();
    end
    rst_    = 1'b1;
    m_owner = -1;
    m_rr    = 0;
    for (int k = 0; k < 5; k++) begin
      check_cycle("reset_order", eg);
      checks++;
      if (bus.gnt !== seq[k]) begin
        errors++;
        $display("FAIL reset_order[%0d]: got %b expected %b", k, bus.gnt, seq[k]);
      end
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_burst();
    logic [N-1:0] eg;
    bus.req      = '0;
    bus.req_last = '0;
    for (int b = 0; b < 5; b++) begin
      set_beat(2, W'(8'h10 + b), (b == 4), 1'b1);
      check_cycle("burst", eg);
      checks++;
      if (bus.fifo_w_en !== 1'b1 || bus.fifo_wr_data !== W'(8'h10 + b)) begin
        errors++;
        $display("FAIL burst[%0d]: got w_en=%b data=%h expected 1/%h", b, bus.fifo_w_en,
                 bus.fifo_wr_data, 8'h10 + b);
      end
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_lock();
    logic [N-1:0] expg [6];
    logic [N-1:0] eg;
    int           p1_sent = 0;
    logic         p0_pend = 1'b0, p3_pend = 1'b0;
    expg = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    bus.req = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        p0_pend = 1'b1;
        p3_pend = 1'b1;
      end
      set_beat(1, W'(8'h30 + p1_sent), (p1_sent == 3), (p1_sent < 4));
      set_beat(0, 8'hC0, 1'b1, p0_pend);
      set_beat(3, 8'hC3, 1'b1, p3_pend);
      check_cycle("lock", eg);
      checks++;
      if (bus.gnt !== expg[c]) begin
        errors++;
        $display("FAIL lock[%0d]: got %b expected %b", c, bus.gnt, expg[c]);
      end
      if (eg[1]) p1_sent++;
      if (eg[0]) p0_pend = 1'b0;
      if (eg[3]) p3_pend = 1'b0;
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_full();
    logic [N-1:0] eg;
    logic [W-1:0] got [$];
    int           sent = 0;
    bus.req = '0;
    for (int c = 0; c < 9; c++) begin
      bus.fifo_full = (c >= 2 && c < 5);
      set_beat(0, W'(8'hA0 + sent), (sent == 5), (sent < 6));
      check_cycle("full", eg);
      if (bus.fifo_full) begin
        checks++;
        if (bus.gnt !== '0 || bus.fifo_w_en !== 1'b0) begin
          errors++;
          $display("FAIL full_hold[%0d]: got gnt=%b w_en=%b expected 0/0", c, bus.gnt,
                   bus.fifo_w_en);
        end
      end
      if (bus.fifo_w_en === 1'b1) got.push_back(bus.fifo_wr_data);
      if (eg[0]) sent++;
      tick();
    end
    bus.fifo_full = 1'b0;
    bus.req       = '0;
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL full_count: got %0d beats expected 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] !== W'(8'hA0 + k)) begin
          errors++;
          $display("FAIL full_seq[%0d]: got %h expected %h", k, got[k], 8'hA0 + k);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [N-1:0] eg;
    bus.req = '0;
    set_beat(3, 8'hD3, 1'b0, 1'b1);
    check_cycle("rst_mid_lock", eg);
    tick();
    rst_ = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_gnt: got %b expected 0000", bus.gnt);
    end
    tick();
    bus.req      = 4'b1001;
    bus.req_last = 4'b1001;
    rst_         = 1'b1;
    m_owner      = -1;
    m_rr         = 0;
    check_cycle("rst_mid_first", eg);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_first: got %b expected 0001", bus.gnt);
    end
    tick();
    bus.req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    logic [W-1:0] cur_d [N];
    logic         cur_l [N];
    logic         pres  [N];
    int           left  [N];
    for (int i = 0; i < N; i++) begin
      pres[i] = 1'b0;
      left[i] = 0;
      cur_d[i] = '0;
      cur_l[i] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pres[i] && $urandom_range(0, 2) == 0) begin
          if (left[i] == 0) left[i] = $urandom_range(1, 4);
          pres[i]  = 1'b1;
          cur_d[i] = W'($urandom);
          cur_l[i] = (left[i] == 1);
        end
        set_beat(i, cur_d[i], cur_l[i], pres[i]);
      end
      bus.fifo_full = ($urandom_range(0, 4) == 0);
      check_cycle("random", eg);
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          pres[i] = 1'b0;
          left[i]--;
        end
      end
      tick();
    end
    bus.fifo_full = 1'b0;
    bus.req       = '0;
  endtask

`ifdef FIFO_WR_ARB_CNT_EN
  task automatic test_counters();
    bus.req       = '0;
    bus.fifo_full = 1'b0;
    cnt_clr       = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (beat_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_clr_init: got %h expected 0", beat_cnt);
    end
    set_beat(1, 8'h55, 1'b1, 1'b1);
    for (int c = 0; c < 70000; c++) begin
      tick();
      if (c == 99) begin
        checks++;
        if (beat_cnt[16 +: 16] !== 16'd100) begin
          errors++;
          $display("FAIL cnt_100: got %0d expected 100", beat_cnt[16 +: 16]);
        end
      end
    end
    checks++;
    if (beat_cnt[16 +: 16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_sat: got %h expected ffff", beat_cnt[16 +: 16]);
    end
    // Clear while producer 1 keeps streaming: clear must win.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (beat_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_clr: got %h expected 0", beat_cnt);
    end
    bus.req = '0;
  endtask
`endif

  initial begin
    rst_          = 1'b0;
    bus.req       = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_CNT_EN
    cnt_clr = 1'b0;
`endif
    tick();
    test_reset();
    test_burst();
    test_lock();
    test_full();
    test_reset_mid_burst();
    test_random();
`ifdef FIFO_WR_ARB_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
